tx_frame_sched: RTL and testbench
=================================

# tx_frame_sched

Transmit frame scheduler for the serial optical link. Generates the word-rate enable for the downstream 8b/10b encoder and decides, word by word, whether the encoder emits an idle comma or a data byte. It wraps each packet from the upstream byte source as SOF, LEN, payload and checksum, and enforces a minimum comma gap between frames.

## Interface
- `MIN_IDLE`, default 4: minimum number of comma words between frames, and after reset. Valid range 1..15.
- `SOF_BYTE`, default 8'hA5: start-of-frame data byte.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `bit_en` in 1: one-cycle strobe, one per serial bit period.
- `word_en` out 1: encoder `nextword_enable`; strobes once every 10 `bit_en`.
- `enc_idle` out 1: encoder `idle`; 1 selects a comma.
- `enc_data` out 8: encoder `d_in`.
- `len_valid` in 1: a frame request is pending.
- `len` in 8: payload length in bytes, 0..255.
- `len_ready` out 1: one-cycle accept of `len`.
- `s_valid` in 1: payload byte available.
- `s_data` in 8: payload byte.
- `s_ready` out 1: payload byte consumed this cycle.
- `busy` out 1: high in SOF, LEN, PAYLOAD and CSUM.
- `frame_done` out 1: one-cycle pulse when the last frame word is consumed.
- `underrun` out 1: one-cycle pulse when a frame is aborted.

## Operation
- Bit counter `bit_cnt` runs 0..9 and advances on `bit_en`, wrapping 9→0. `word_en = bit_en & (bit_cnt==9)`; this output is combinational.
- The state holds the symbol currently presented on `enc_idle`/`enc_data`. On a `word_en` cycle the encoder consumes that symbol, and the state updates in the same edge.
- IDLE: presents a comma (`enc_idle=1`, `enc_data=0`). On each `word_en`, `gap_cnt` increments, saturating at 15.
  - Leave IDLE when `word_en & len_valid & (gap_cnt+1 >= MIN_IDLE)`. In that cycle `len_ready=1`, `len_q<=len`, and the state moves to SOF.
- SOF: presents `SOF_BYTE`. On `word_en`, go to LEN.
- LEN: presents `len_q`. On `word_en`, `csum<=len_q` and `rem<=len_q`. Go to PAYLOAD if `len_q!=0`, else to CSUM.
- PAYLOAD: presents `s_data`, with `enc_idle=~s_valid` (combinational). `s_ready = word_en & (state==PAYLOAD)`. On `word_en`:
  - If `s_valid`: `csum<=csum+s_data` (mod 256) and `rem<=rem-1`. When `rem==1`, go to CSUM.
  - If `~s_valid`: the comma already went out, so pulse `underrun`, set `gap_cnt<=1`, and go to IDLE. Any bytes not yet sent are left for the source to discard.
- CSUM: presents `(~csum)+1`, so the LEN, payload and checksum bytes sum to 0 mod 256. On `word_en`, pulse `frame_done`, set `gap_cnt<=0`, and go to IDLE.
- `len_valid` is ignored outside IDLE. `s_valid` is ignored outside PAYLOAD.

## Timing
- Reset values: state IDLE, `bit_cnt=0`, `gap_cnt=0`, `csum=0`, `rem=0`, `len_q=0`.
- Reset output values: `word_en=0` (while `bit_en` is low), `enc_idle=1`, `enc_data=0`, `len_ready=0`, `s_ready=0`, `busy=0`, `frame_done=0`, `underrun=0`.
- The first `word_en` occurs on the 10th `bit_en` after reset release. The first SOF word is consumed no earlier than word MIN_IDLE+1.
- Frame length on the line is `len_q+3` words, or `len_q+2` words without checksum.
- Throughput with back-to-back requests: one frame every `len+3+MIN_IDLE` words.
- An `rst` mid-frame abandons the frame immediately. No `frame_done` or `underrun` pulse is generated.
- If `bit_en` is held high every cycle, `word_en` fires every 10 cycles.

## Configuration
- `TX_SCHED_CSUM_EN` defined: CSUM state present and behaviour as above.
- `TX_SCHED_CSUM_EN` undefined: CSUM state and `csum` register removed. The last PAYLOAD word, or the LEN word when `len_q==0`, goes directly to IDLE with `frame_done`, and frames are `len_q+2` words.

## Test plan
- Reset with `len_valid=1` held and `bit_en` every cycle: exactly 4 commas, then SOF 0xA5; `len_ready` pulses on the 4th `word_en`.
- `len=2`, payload 0x10, 0x20, always valid: words are A5, 02, 10, 20, CE, then commas; `frame_done` on the CE word; `s_ready` pulses twice.
- `len=0`: words are A5, 00, 00, then ≥4 commas before the next SOF.
- `len=3`, `s_valid` dropped at the 2nd payload word: words are A5, 03, b0, comma; `underrun` pulses once; next SOF appears after ≥3 further commas.
- Back-to-back requests of `len=1` (0xFF): line repeats A5, 01, FF, 00, then exactly 4 commas.
- With `TX_SCHED_CSUM_EN` undefined, `len=2` (0x10, 0x20): words are A5, 02, 10, 20, then comma; `frame_done` on the 0x20 word.

Source files
------------

// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler: word-rate enable and SOF/LEN/payload[/checksum] framing with a minimum comma gap.
// Optional checksum word enabled by defining TX_SCHED_CSUM_EN.
module tx_frame_sched #(
   parameter int unsigned MIN_IDLE = 4,
   parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_en,
   output logic       word_en,
   output logic       enc_idle,
   output logic [7:0] enc_data,
   input  logic       len_valid,
   input  logic [7:0] len,
   output logic       len_ready,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_LEN,
`ifdef TX_SCHED_CSUM_EN
      ST_CSUM,
`endif
      ST_PAYLOAD
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;
   logic [7:0] rem_q, rem_d;
   logic [7:0] len_q, len_d;
`ifdef TX_SCHED_CSUM_EN
   logic [7:0] csum_q, csum_d;
`endif

   logic [3:0] gap_inc;
   logic       gap_ok;

   assign word_en = bit_en & (bit_cnt_q == 4'd9);
   assign busy    = (state_q != ST_IDLE);
   assign gap_inc = (gap_cnt_q == 4'd15) ? 4'd15 : gap_cnt_q + 4'd1;
   // Gap test uses the count including the comma being consumed now.
   assign gap_ok  = ({1'b0, gap_cnt_q} + 5'd1) >= 5'(MIN_IDLE);

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (bit_en) begin
         bit_cnt_d = (bit_cnt_q == 4'd9) ? '0 : bit_cnt_q + 4'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      rem_d      = rem_q;
      len_d      = len_q;
`ifdef TX_SCHED_CSUM_EN
      csum_d     = csum_q;
`endif
      enc_idle   = 1'b0;
      enc_data   = '0;
      len_ready  = 1'b0;
      s_ready    = 1'b0;
      frame_done = 1'b0;
      underrun   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            enc_idle = 1'b1;
            if (word_en) begin
               gap_cnt_d = gap_inc;
               if (len_valid && gap_ok) begin
                  len_ready = 1'b1;
                  len_d     = len;
                  state_d   = ST_SOF;
               end
            end
         end
         ST_SOF: begin
            enc_data = SOF_BYTE;
            if (word_en) state_d = ST_LEN;
         end
         ST_LEN: begin
            enc_data = len_q;
            if (word_en) begin
               rem_d = len_q;
`ifdef TX_SCHED_CSUM_EN
               csum_d = len_q;
`endif
               if (len_q != 8'd0) begin
                  state_d = ST_PAYLOAD;
               end else begin
`ifdef TX_SCHED_CSUM_EN
                  state_d = ST_CSUM;
`else
                  frame_done = 1'b1;
                  gap_cnt_d  = '0;
                  state_d    = ST_IDLE;
`endif
               end
            end
         end
         ST_PAYLOAD: begin
            enc_data = s_data;
            enc_idle = ~s_valid;
            s_ready  = word_en;
            if (word_en) begin
               if (s_valid) begin
`ifdef TX_SCHED_CSUM_EN
                  csum_d = csum_q + s_data;
`endif
                  rem_d = rem_q - 8'd1;
                  if (rem_q == 8'd1) begin
`ifdef TX_SCHED_CSUM_EN
                     state_d = ST_CSUM;
`else
                     frame_done = 1'b1;
                     gap_cnt_d  = '0;
                     state_d    = ST_IDLE;
`endif
                  end
               end else begin
                  // The comma just sent already counts towards the next gap.
                  underrun  = 1'b1;
                  gap_cnt_d = 4'd1;
                  state_d   = ST_IDLE;
               end
            end
         end
`ifdef TX_SCHED_CSUM_EN
         ST_CSUM: begin
            enc_data = (~csum_q) + 8'd1;
            if (word_en) begin
               frame_done = 1'b1;
               gap_cnt_d  = '0;
               state_d    = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         rem_q     <= '0;
         len_q     <= '0;
`ifdef TX_SCHED_CSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         rem_q     <= rem_d;
         len_q     <= len_d;
`ifdef TX_SCHED_CSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed word-level bench for tx_frame_sched; expectations follow TX_SCHED_CSUM_EN.
module tb_tx_frame_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       bit_en;
   logic       word_en;
   logic       enc_idle;
   logic [7:0] enc_data;
   logic       len_valid;
   logic [7:0] len;
   logic       len_ready;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       busy;
   logic       frame_done;
   logic       underrun;

   int errors = 0;
   int checks = 0;
   int be_mode = 0;
   int be_phase = 0;
   bit mon_en = 1'b0;
   int pulse_cnt = 0;

   tx_frame_sched #(.MIN_IDLE(4), .SOF_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .bit_en(bit_en), .word_en(word_en),
      .enc_idle(enc_idle), .enc_data(enc_data),
      .len_valid(len_valid), .len(len), .len_ready(len_ready),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .busy(busy), .frame_done(frame_done), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // bit_en: off, every cycle, or one cycle in be_mode
   initial begin
      bit_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (be_mode == 0) begin
            bit_en = 1'b0;
         end else begin
            bit_en = (be_phase == 0);
            be_phase = (be_phase + 1) % be_mode;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && (frame_done === 1'b1 || underrun === 1'b1)) pulse_cnt++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       lv;
      logic [7:0] ln;
      logic       sv;
      logic [7:0] sd;
      logic       ei;
      logic [7:0] ed;
      logic       lr;
      logic       sr;
      logic       bz;
      logic       fd;
      logic       ur;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic lv, input logic [7:0] ln, input logic sv, input logic [7:0] sd,
                      input logic ei, input logic [7:0] ed, input logic lr, input logic sr,
                      input logic bz, input logic fd, input logic ur);
      vec_t v;
      v.lv = lv; v.ln = ln; v.sv = sv; v.sd = sd; v.ei = ei; v.ed = ed;
      v.lr = lr; v.sr = sr; v.bz = bz; v.fd = fd; v.ur = ur;
      vq.push_back(v);
   endtask

   task automatic comma(input logic lv, input logic [7:0] ln, input logic lr);
      add(lv, ln, 1'b1, 8'h55, 1'b1, 8'h00, lr, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // len=1 frame with payload 0xFF, next request (len=1) held throughout
   task automatic frame_ff();
      add(1, 8'd1, 1, 8'h55, 0, 8'hA5, 0, 0, 1, 0, 0);
      add(1, 8'd1, 1, 8'h55, 0, 8'h01, 0, 0, 1, 0, 0);
`ifdef TX_SCHED_CSUM_EN
      add(1, 8'd1, 1, 8'hFF, 0, 8'hFF, 0, 1, 1, 0, 0);
      add(1, 8'd1, 1, 8'h55, 0, 8'h00, 0, 0, 1, 1, 0);
`else
      add(1, 8'd1, 1, 8'hFF, 0, 8'hFF, 0, 1, 1, 1, 0);
`endif
   endtask

   task automatic wait_word(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (word_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL word_timeout: got no word_en expected word_en within %0d cycles", max_cyc);
      end
   endtask

   initial begin
      bit ok;
      int n;
      int commas;

      rst = 1'b1; len_valid = 1'b1; len = 8'd2; s_valid = 1'b0; s_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_word_en", word_en, 0);
      chk("rst_enc_idle", enc_idle, 1);
      chk("rst_enc_data", enc_data, 8'h00);
      chk("rst_len_ready", len_ready, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_underrun", underrun, 0);

      // frame len=2, payload 10 20
      comma(1, 8'd2, 0); comma(1, 8'd2, 0); comma(1, 8'd2, 0); comma(1, 8'd2, 1);
      add(0, 8'd0, 1, 8'h55, 0, 8'hA5, 0, 0, 1, 0, 0);
      add(1, 8'd9, 1, 8'h55, 0, 8'h02, 0, 0, 1, 0, 0);
      add(1, 8'd9, 1, 8'h10, 0, 8'h10, 0, 1, 1, 0, 0);
`ifdef TX_SCHED_CSUM_EN
      add(1, 8'd9, 1, 8'h20, 0, 8'h20, 0, 1, 1, 0, 0);
      add(0, 8'd0, 1, 8'h55, 0, 8'hCE, 0, 0, 1, 1, 0);
`else
      add(0, 8'd0, 1, 8'h20, 0, 8'h20, 0, 1, 1, 1, 0);
`endif
      // frame len=0
      comma(1, 8'd0, 0); comma(1, 8'd0, 0); comma(1, 8'd0, 0); comma(1, 8'd0, 1);
      add(0, 8'd0, 1, 8'h55, 0, 8'hA5, 0, 0, 1, 0, 0);
`ifdef TX_SCHED_CSUM_EN
      add(0, 8'd0, 1, 8'h55, 0, 8'h00, 0, 0, 1, 0, 0);
      add(0, 8'd0, 1, 8'h55, 0, 8'h00, 0, 0, 1, 1, 0);
`else
      add(0, 8'd0, 1, 8'h55, 0, 8'h00, 0, 0, 1, 1, 0);
`endif
      // frame len=3 with underrun on second payload word
      comma(1, 8'd3, 0); comma(1, 8'd3, 0); comma(1, 8'd3, 0); comma(1, 8'd3, 1);
      add(0, 8'd0, 1, 8'h55, 0, 8'hA5, 0, 0, 1, 0, 0);
      add(0, 8'd0, 1, 8'h55, 0, 8'h03, 0, 0, 1, 0, 0);
      add(0, 8'd0, 1, 8'hB0, 0, 8'hB0, 0, 1, 1, 0, 0);
      add(0, 8'd0, 0, 8'h00, 1, 8'h00, 0, 1, 1, 0, 1);
      // three more commas then back-to-back len=1 frames
      comma(1, 8'd1, 0); comma(1, 8'd1, 0); comma(1, 8'd1, 1);
      frame_ff();
      comma(1, 8'd1, 0); comma(1, 8'd1, 0); comma(1, 8'd1, 0); comma(1, 8'd1, 1);
      frame_ff();
      comma(0, 8'd0, 0); comma(0, 8'd0, 0); comma(0, 8'd0, 0); comma(0, 8'd0, 0); comma(0, 8'd0, 0);

      @(posedge clk);
      #1;
      rst = 1'b0;
      be_mode = 1;

      for (int k = 0; k < vq.size(); k++) begin
         len_valid = vq[k].lv; len = vq[k].ln; s_valid = vq[k].sv; s_data = vq[k].sd;
         wait_word(25, ok);
         if (ok) begin
            chk($sformatf("w%0d_enc_idle", k), enc_idle, vq[k].ei);
            chk($sformatf("w%0d_enc_data", k), enc_data, vq[k].ed);
            chk($sformatf("w%0d_len_ready", k), len_ready, vq[k].lr);
            chk($sformatf("w%0d_s_ready", k), s_ready, vq[k].sr);
            chk($sformatf("w%0d_busy", k), busy, vq[k].bz);
            chk($sformatf("w%0d_frame_done", k), frame_done, vq[k].fd);
            chk($sformatf("w%0d_underrun", k), underrun, vq[k].ur);
         end
         @(posedge clk);
         #1;
      end

      // word_en period with bit_en held high
      wait_word(25, ok);
      n = 0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (word_en === 1'b1) begin
            n = i;
            break;
         end
      end
      chk("word_period_cycles", n, 10);

      // sparse bit_en: ten strobes per word
      be_mode = 3;
      be_phase = 0;
      wait_word(60, ok);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bit_en === 1'b1) n++;
         if (word_en === 1'b1) break;
      end
      chk("sparse_bit_en_per_word", n, 10);

      // reset mid-frame
      be_mode = 1;
      @(posedge clk);
      #1;
      len_valid = 1'b1; len = 8'd5; s_valid = 1'b1; s_data = 8'h33;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         wait_word(25, ok);
         if (ok && enc_idle === 1'b0) begin
            n = 1;
            break;
         end
      end
      chk("midrst_sof_seen", n, 1);
      @(posedge clk);
      #1;
      len_valid = 1'b0;
      mon_en = 1'b1;
      pulse_cnt = 0;
      repeat (14) @(posedge clk);
      #4;
      chk("midrst_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_enc_idle", enc_idle, 1);
      chk("midrst_enc_data", enc_data, 8'h00);
      len_valid = 1'b1; len = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      commas = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bit_en === 1'b1) n++;
         if (word_en === 1'b1) break;
      end
      chk("first_word_bit_en_count", n, 10);
      if (word_en === 1'b1 && enc_idle === 1'b1) commas = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         wait_word(25, ok);
         if (!ok || enc_idle !== 1'b1) break;
         commas++;
         @(posedge clk);
         #1;
      end
      chk("midrst_commas_before_sof", commas, 4);
      chk("midrst_next_sof", enc_data, 8'hA5);
      mon_en = 1'b0;
      chk("midrst_no_pulses", pulse_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
